// File: rtl/branch_pkg.sv
// Shared types for E-stage branch resolution: branch type enum,
// MIPS opcode constants, D->E branch bundle and the brtype decoder.
package branch_pkg;

    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;

    typedef enum logic [3:0] {
        BR_NONE,
        BR_BEQ,
        BR_BNE,
        BR_BLEZ,
        BR_BGTZ,
        BR_BLTZ,
        BR_BGEZ,
        BR_BLTZAL,
        BR_BGEZAL,
        BR_BLTZL,
        BR_BGEZL,
        BR_BLTZALL,
        BR_BGEZALL
    } br_type_e;

    // pc is kept at full 32 bits; the top truncates to PC_W (PC_W <= 32).
    typedef struct packed {
        logic        valid;
        logic        pred_take;
        br_type_e    brtype;
        logic [31:0] pc;
        logic [31:0] imm;
    } br_info_t;

    function automatic br_type_e decode_brtype(
        input logic [5:0] op,
        input logic [4:0] rt
    );
        br_type_e t;
        t = BR_NONE;
        case (op)
            OP_BEQ:  t = BR_BEQ;
            OP_BNE:  t = BR_BNE;
            OP_BLEZ: t = BR_BLEZ;
            OP_BGTZ: t = BR_BGTZ;
            OP_REGIMM: begin
                // rt[4] = link, rt[1] = likely, rt[0] = GEZ; rt[3:2] must be 0
                if (rt[3:2] == 2'b00) begin
                    case ({rt[4], rt[1], rt[0]})
                        3'b000: t = BR_BLTZ;
                        3'b001: t = BR_BGEZ;
                        3'b010: t = BR_BLTZL;
                        3'b011: t = BR_BGEZL;
                        3'b100: t = BR_BLTZAL;
                        3'b101: t = BR_BGEZAL;
                        3'b110: t = BR_BLTZALL;
                        3'b111: t = BR_BGEZALL;
                    endcase
                end
            end
            default: t = BR_NONE;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/branch_cond.sv
// Combinational MIPS branch condition on signed 32-bit operands.
// Ports: brtype_i, rs_i, rt_i -> cond_o.
module branch_cond
    import branch_pkg::*;
(
    input  br_type_e    brtype_i,
    input  logic [31:0] rs_i,
    input  logic [31:0] rt_i,
    output logic        cond_o
);

    logic rs_neg;
    logic rs_zero;

    assign rs_neg  = rs_i[31];
    assign rs_zero = (rs_i == 32'd0);

    always_comb begin
        cond_o = 1'b0;
        unique case (brtype_i)
            BR_BEQ:     cond_o = (rs_i == rt_i);
            BR_BNE:     cond_o = (rs_i != rt_i);
            BR_BLEZ:    cond_o = rs_neg | rs_zero;
            BR_BGTZ:    cond_o = ~rs_neg & ~rs_zero;
            BR_BLTZ,
            BR_BLTZAL,
            BR_BLTZL,
            BR_BLTZALL: cond_o = rs_neg;
            BR_BGEZ,
            BR_BGEZAL,
            BR_BGEZL,
            BR_BGEZALL: cond_o = ~rs_neg;
            default:    cond_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve.sv
// E-stage branch resolution: D->E branch register, condition evaluation,
// predictor update bundle, misprediction detect and held front-end redirect.
// Ports: clk/rst (sync, active-high), stallE/flushE, D-side branch info,
// forwarded rs/rt, redirect handshake, predictor update and redirect outputs.
// Optional macro BRANCH_STATS_EN adds stat_branches / stat_mispred counters.
module branch_resolve
    import branch_pkg::*;
#(
    parameter int PC_W         = 32,
    parameter int RESET_PC_OFS = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stallE,
    input  logic            flushE,
    input  logic            branchD,
    input  logic            pred_takeD,
    input  logic [31:0]     instrD,
    input  logic [PC_W-1:0] pcD,
    input  logic [31:0]     immD,
    input  logic [31:0]     rs_valueE,
    input  logic [31:0]     rt_valueE,
    input  logic            redirect_ready,
    output logic            branchE,
    output logic [PC_W-1:0] pcE,
    output logic            actual_takeE,
    output logic            mispredictE,
    output logic            redirect_valid,
    output logic [PC_W-1:0] redirect_pc,
    output logic            flush_front,
    output logic            stall_req
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispred
`endif
);

    br_info_t        e_q, e_d;
    br_type_e        brtype_d;
    logic            cond;
    logic [PC_W-1:0] taken_tgt;
    logic [PC_W-1:0] fall_tgt;
    logic            rv_q, rv_d;
    logic [PC_W-1:0] rpc_q, rpc_d;
    logic            rd_load;
    logic            unused_instr;

    // Only opcode and rt select the branch type.
    assign unused_instr = ^{instrD[25:21], instrD[15:0]};
    assign brtype_d     = decode_brtype(instrD[31:26], instrD[20:16]);

    always_comb begin
        e_d = e_q;
        if (flushE) begin
            e_d = '0;
        end else if (!stallE) begin
            e_d.brtype    = brtype_d;
            e_d.valid     = branchD & (brtype_d != BR_NONE);
            e_d.pred_take = pred_takeD;
            e_d.pc        = 32'(pcD);
            e_d.imm       = immD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) e_q <= '0;
        else     e_q <= e_d;
    end

    branch_cond u_cond (
        .brtype_i (e_q.brtype),
        .rs_i     (rs_valueE),
        .rt_i     (rt_valueE),
        .cond_o   (cond)
    );

    assign branchE      = e_q.valid;
    assign pcE          = e_q.pc[PC_W-1:0];
    assign actual_takeE = e_q.valid & cond;
    assign mispredictE  = e_q.valid & (actual_takeE != e_q.pred_take);

    assign taken_tgt = pcE + PC_W'(4) + PC_W'(e_q.imm << 2);
    assign fall_tgt  = pcE + PC_W'(RESET_PC_OFS);

    // A stalled E branch waits so the redirect is issued exactly once.
    // A new load beats the accept-clear in the same cycle.
    assign rd_load = mispredictE & ~stallE & (~rv_q | redirect_ready);

    always_comb begin
        rv_d  = rv_q;
        rpc_d = rpc_q;
        if (rd_load) begin
            rv_d  = 1'b1;
            rpc_d = actual_takeE ? taken_tgt : fall_tgt;
        end else if (rv_q & redirect_ready) begin
            rv_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rv_q  <= 1'b0;
            rpc_q <= '0;
        end else begin
            rv_q  <= rv_d;
            rpc_q <= rpc_d;
        end
    end

    assign redirect_valid = rv_q;
    assign redirect_pc    = rpc_q;
    assign flush_front    = rv_q;
    assign stall_req      = rv_q & ~redirect_ready;

`ifdef BRANCH_STATS_EN
    logic [31:0] br_cnt_q;
    logic [31:0] mis_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            br_cnt_q  <= '0;
            mis_cnt_q <= '0;
        end else begin
            if (branchE && !stallE && br_cnt_q != '1)
                br_cnt_q <= br_cnt_q + 32'd1;
            if (mispredictE && !stallE && mis_cnt_q != '1)
                mis_cnt_q <= mis_cnt_q + 32'd1;
        end
    end

    assign stat_branches = br_cnt_q;
    assign stat_mispred  = mis_cnt_q;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed cases plus random
// branches against a field-level reference model of MIPS branch rules.
module tb_branch_resolve;

    logic        clk;
    logic        rst;
    logic        stallE;
    logic        flushE;
    logic        branchD;
    logic        pred_takeD;
    logic [31:0] instrD;
    logic [31:0] pcD;
    logic [31:0] immD;
    logic [31:0] rs_valueE;
    logic [31:0] rt_valueE;
    logic        redirect_ready;
    logic        branchE;
    logic [31:0] pcE;
    logic        actual_takeE;
    logic        mispredictE;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush_front;
    logic        stall_req;
`ifdef BRANCH_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispred;
`endif

    int          vectors = 0;
    int          miscompares = 0;
    logic        exp_mis;
    logic [31:0] exp_tgt;

    branch_resolve dut (
        .clk            (clk),
        .rst            (rst),
        .stallE         (stallE),
        .flushE         (flushE),
        .branchD        (branchD),
        .pred_takeD     (pred_takeD),
        .instrD         (instrD),
        .pcD            (pcD),
        .immD           (immD),
        .rs_valueE      (rs_valueE),
        .rt_valueE      (rt_valueE),
        .redirect_ready (redirect_ready),
        .branchE        (branchE),
        .pcE            (pcE),
        .actual_takeE   (actual_takeE),
        .mispredictE    (mispredictE),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush_front    (flush_front),
        .stall_req      (stall_req)
`ifdef BRANCH_STATS_EN
        ,
        .stat_branches  (stat_branches),
        .stat_mispred   (stat_mispred)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc(input int op, input int rt,
                                        input logic [15:0] i16);
        return {op[5:0], 5'd3, rt[4:0], i16};
    endfunction

    function automatic bit ref_isbr(input logic [31:0] ins);
        int op;
        int r;
        op = int'(ins[31:26]);
        r  = int'(ins[20:16]);
        if (op >= 4 && op <= 7) return 1'b1;
        if (op == 1) return (r % 16) < 4;
        return 1'b0;
    endfunction

    function automatic bit ref_take(input logic [31:0] ins,
                                    input logic [31:0] rs,
                                    input logic [31:0] rt);
        int op;
        int r;
        int s;
        op = int'(ins[31:26]);
        r  = int'(ins[20:16]);
        s  = $signed(rs);
        case (op)
            4:       return rs == rt;
            5:       return rs != rt;
            6:       return s <= 0;
            7:       return s > 0;
            default: return (r % 2 == 1) ? (s >= 0) : (s < 0);
        endcase
    endfunction

    task automatic drive_d(input logic [31:0] ins, input logic [31:0] pc,
                           input logic [31:0] imm, input logic pred);
        branchD    = 1'b1;
        instrD     = ins;
        pcD        = pc;
        immD       = imm;
        pred_takeD = pred;
    endtask

    task automatic bubble_d;
        branchD    = 1'b0;
        pred_takeD = 1'b0;
        instrD     = 32'd0;
    endtask

    task automatic check_e(input logic [31:0] ins, input logic [31:0] pc,
                           input logic [31:0] imm, input logic pred,
                           input logic [31:0] rs, input logic [31:0] rt);
        bit v;
        bit t;
        rs_valueE = rs;
        rt_valueE = rt;
        #1;
        v = ref_isbr(ins);
        t = v && ref_take(ins, rs, rt);
        exp_mis = v && (t != pred);
        exp_tgt = t ? (pc + 32'd4 + imm * 32'd4) : (pc + 32'd8);
        chk("branchE", {31'd0, branchE}, {31'd0, v});
        chk("actual_takeE", {31'd0, actual_takeE}, {31'd0, t});
        chk("mispredictE", {31'd0, mispredictE}, {31'd0, exp_mis});
        chk("pcE", pcE, pc);
    endtask

    task automatic resolve(input logic [31:0] ins, input logic [31:0] pc,
                           input logic [31:0] imm, input logic pred,
                           input logic [31:0] rs, input logic [31:0] rt);
        drive_d(ins, pc, imm, pred);
        tick;
        bubble_d;
        check_e(ins, pc, imm, pred, rs, rt);
        tick;
        chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, exp_mis});
        chk("flush_front", {31'd0, flush_front}, {31'd0, exp_mis});
        chk("stall_req", {31'd0, stall_req}, 32'd0);
        if (exp_mis) chk("redirect_pc", redirect_pc, exp_tgt);
        tick;
        chk("redirect_clear", {31'd0, redirect_valid}, 32'd0);
    endtask

    initial begin
        logic [31:0] ins;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [15:0] i16;
        logic [31:0] ins2;
        logic [31:0] tgt1;
        int          op;
        int          code;
        int          ops[10];

        rst = 1'b1; stallE = 1'b0; flushE = 1'b0;
        bubble_d;
        pcD = 32'd0; immD = 32'd0;
        rs_valueE = 32'd0; rt_valueE = 32'd0;
        redirect_ready = 1'b1;
        tick;
        tick;
        chk("rst_branchE", {31'd0, branchE}, 32'd0);
        chk("rst_pcE", pcE, 32'd0);
        chk("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        chk("rst_stall_req", {31'd0, stall_req}, 32'd0);
        rst = 1'b0;

        resolve(enc(4, 0, 16'd3), 32'h1000, 32'd3, 1'b0, 32'd5, 32'd5);
        resolve(enc(5, 0, 16'd7), 32'h2000, 32'd7, 1'b1, 32'd9, 32'd9);
        resolve(enc(7, 0, 16'd2), 32'h3000, 32'd2, 1'b0,
                32'h8000_0000, 32'd0);
        resolve(enc(7, 0, 16'd2), 32'h3000, 32'd2, 1'b1, 32'd1, 32'd0);

        // redirect held while fetch refuses it
        redirect_ready = 1'b0;
        ins = enc(4, 0, 16'hFFFF);
        drive_d(ins, 32'h4000, 32'hFFFF_FFFF, 1'b0);
        tick;
        bubble_d;
        check_e(ins, 32'h4000, 32'hFFFF_FFFF, 1'b0, 32'd1, 32'd1);
        tick;
        for (int i = 0; i < 3; i++) begin
            chk("hold_valid", {31'd0, redirect_valid}, 32'd1);
            chk("hold_stall_req", {31'd0, stall_req}, 32'd1);
            chk("hold_pc", redirect_pc, 32'h4000);
            tick;
        end
        redirect_ready = 1'b1;
        #1;
        chk("accept_stall_req", {31'd0, stall_req}, 32'd0);
        tick;
        chk("accept_clear", {31'd0, redirect_valid}, 32'd0);

        // back-to-back mispredicts: new load beats the accept-clear
        ins  = enc(6, 0, 16'd4);
        ins2 = enc(1, 1, 16'd8);
        drive_d(ins, 32'h5000, 32'd4, 1'b0);
        tick;
        drive_d(ins2, 32'h6000, 32'd8, 1'b0);
        check_e(ins, 32'h5000, 32'd4, 1'b0, 32'd0, 32'd0);
        tgt1 = exp_tgt;
        tick;
        bubble_d;
        chk("b2b_first_pc", redirect_pc, tgt1);
        check_e(ins2, 32'h6000, 32'd8, 1'b0, 32'd4, 32'd0);
        chk("b2b_second_mis", {31'd0, mispredictE}, 32'd1);
        tick;
        chk("b2b_valid", {31'd0, redirect_valid}, 32'd1);
        chk("b2b_second_pc", redirect_pc, exp_tgt);
        tick;
        chk("b2b_clear", {31'd0, redirect_valid}, 32'd0);

        // stalled branch issues its redirect only once released
        ins = enc(4, 0, 16'd1);
        drive_d(ins, 32'h7000, 32'd1, 1'b0);
        tick;
        bubble_d;
        stallE = 1'b1;
        check_e(ins, 32'h7000, 32'd1, 1'b0, 32'd2, 32'd2);
        tick;
        chk("stall_no_redirect", {31'd0, redirect_valid}, 32'd0);
        chk("stall_hold_branchE", {31'd0, branchE}, 32'd1);
        tick;
        chk("stall_no_redirect2", {31'd0, redirect_valid}, 32'd0);
        stallE = 1'b0;
        tick;
        chk("stall_release", {31'd0, redirect_valid}, 32'd1);
        chk("stall_release_pc", redirect_pc, 32'h7008);
        tick;
        chk("stall_once", {31'd0, redirect_valid}, 32'd0);

        // flushE kills a loading branch
        drive_d(enc(4, 0, 16'd3), 32'h8000, 32'd3, 1'b0);
        flushE = 1'b1;
        tick;
        flushE = 1'b0;
        bubble_d;
        rs_valueE = 32'd5; rt_valueE = 32'd5;
        #1;
        chk("flush_branchE", {31'd0, branchE}, 32'd0);
        chk("flush_mis", {31'd0, mispredictE}, 32'd0);
        tick;
        chk("flush_no_redirect", {31'd0, redirect_valid}, 32'd0);

        // rst drops a pending redirect
        redirect_ready = 1'b0;
        ins = enc(4, 0, 16'd3);
        drive_d(ins, 32'h9000, 32'd3, 1'b0);
        tick;
        bubble_d;
        check_e(ins, 32'h9000, 32'd3, 1'b0, 32'd5, 32'd5);
        tick;
        chk("pre_rst_valid", {31'd0, redirect_valid}, 32'd1);
        rst = 1'b1;
        tick;
        chk("rst_drop_valid", {31'd0, redirect_valid}, 32'd0);
        chk("rst_drop_branchE", {31'd0, branchE}, 32'd0);
        rst = 1'b0;
        redirect_ready = 1'b1;

        ops = '{4, 5, 6, 7, 1, 1, 1, 0, 2, 35};
        for (int n = 0; n < 40; n++) begin
            op   = ops[$urandom_range(0, 9)];
            code = $urandom_range(0, 31);
            i16  = 16'($urandom);
            imm  = {{16{i16[15]}}, i16};
            ins  = enc(op, code, i16);
            pc   = $urandom & 32'hFFFF_FFFC;
            rt   = $urandom;
            case ($urandom_range(0, 7))
                0:       rs = rt;
                1:       rs = 32'd0;
                2:       rs = 32'h8000_0000;
                default: rs = $urandom;
            endcase
            resolve(ins, pc, imm, 1'($urandom_range(0, 1)), rs, rt);
        end

`ifdef BRANCH_STATS_EN
        rst = 1'b1;
        tick;
        rst = 1'b0;
        resolve(enc(4, 0, 16'd3), 32'h1000, 32'd3, 1'b0, 32'd5, 32'd5);
        resolve(enc(5, 0, 16'd3), 32'h1100, 32'd3, 1'b1, 32'd1, 32'd2);
        resolve(enc(7, 0, 16'd3), 32'h1200, 32'd3, 1'b1, 32'd0, 32'd0);
        resolve(enc(6, 0, 16'd3), 32'h1300, 32'd3, 1'b1, 32'd0, 32'd0);
        chk("stat_branches", stat_branches, 32'd4);
        chk("stat_mispred", stat_mispred, 32'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
- Execute-stage consumer of the decode-stage branch predictor outputs (branchD, pred_takeD).
- Holds the D->E branch pipeline register and evaluates the MIPS branch condition on forwarded operands. Produces the predictor update bundle (pcE, branchE, actual_takeE).
- Detects mispredictions and issues a registered, held-until-accepted front-end redirect with a flush request.

Parameters:
- PC_W, 32, PC and target width
- RESET_PC_OFS, 8, not-taken fall-through offset from the branch PC (branch plus delay slot)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- stallE  in  1  hold the E register
- flushE  in  1  clear the E register to a bubble
- branchD  in  1  decode says the instruction is a branch
- pred_takeD  in  1  decode prediction: taken
- instrD  in  32  decode instruction word
- pcD  in  PC_W  decode PC
- immD  in  32  sign-extended immediate
- rs_valueE  in  32  forwarded rs operand in E
- rt_valueE  in  32  forwarded rt operand in E
- redirect_ready  in  1  fetch accepts the redirect this cycle
- branchE  out  1  valid branch in E (predictor update enable)
- pcE  out  PC_W  PC of the E instruction
- actual_takeE  out  1  resolved direction
- mispredictE  out  1  combinational: branchE & (actual_takeE != pred_takeE)
- redirect_valid  out  1  registered redirect request
- redirect_pc  out  PC_W  redirect target
- flush_front  out  1  flush F/D; equals redirect_valid
- stall_req  out  1  redirect_valid & ~redirect_ready

Behaviour:
- E register fields: valid_br, pred_take, brtype, pc, imm.
  - rst or flushE: all fields cleared (bubble).
  - else if stallE: hold.
  - else: load from D; valid_br = branchD.
- brtype decode from instrD:
  - opcodes 000100 BEQ, 000101 BNE, 000110 BLEZ, 000111 BGTZ.
  - REGIMM (000001) with rt[4:0] in {00000 BLTZ, 00001 BGEZ, 10000 BLTZAL, 10001 BGEZAL} plus the likely forms (rt[1] set).
  - Any other encoding: brtype = NONE, valid_br = 0.
- Condition evaluation, pure combinational in E, signed 32-bit:
  - BEQ: rs == rt. BNE: rs != rt.
  - BLEZ: rs <= 0. BGTZ: rs > 0.
  - BLTZ*: rs[31]. BGEZ*: ~rs[31].
- actual_takeE = valid_br & cond. branchE = valid_br. Both are valid in the same cycle the instruction sits in E.
- Targets:
  - taken_tgt = pc + 4 + (imm << 2), 32-bit wrap-around, no overflow trap.
  - fall_tgt = pc + RESET_PC_OFS.
- Redirect register:
  - rst: redirect_valid = 0, redirect_pc = 0.
  - Idle with mispredictE and ~stallE: on the next edge redirect_valid = 1 and redirect_pc = actual_takeE ? taken_tgt : fall_tgt. Latency is 1 cycle from resolution.
  - While redirect_valid & ~redirect_ready: hold value, assert stall_req. A new mispredict is ignored; it cannot occur because the front end is flushed.
  - redirect_valid & redirect_ready: clear on the next edge. A mispredict in the same cycle loads the new redirect instead (load wins).
  - flushE does not cancel a pending redirect.
  - rst mid-redirect drops it.
- Stalled E branch (stallE = 1): mispredictE may be high, but no redirect is loaded until the stall releases, so the redirect is issued once.
- Correct prediction: no redirect, no flush.

Optional Feature:
- BRANCH_STATS_EN
  - Defined: adds outputs stat_branches[31:0] and stat_mispred[31:0].
  - Each counter increments once per retired E branch (branchE & ~stallE), respectively per mispredict. Counters are cleared by rst and saturate at 32'hFFFF_FFFF.
  - Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package branch_pkg holds:
  - br_type_e enum (NONE, BEQ, BNE, BLEZ, BGTZ, BLTZ, BGEZ, BLTZAL, BGEZAL, plus the L variants);
  - opcode constants OP_REGIMM, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ;
  - a packed struct br_info_t {valid, pred_take, brtype, pc, imm}.
- One sub-module, branch_cond: combinational (brtype, rs, rt) -> cond, reusable by the verifier's reference model.

Test Plan:
- BEQ at pc 0x1000, imm 3, rs = rt = 5, pred_take 0 -> branchE = 1, actual_takeE = 1, mispredictE = 1; next cycle redirect_valid = 1, redirect_pc = 0x1010.
- BNE at 0x2000, rs = rt, pred_take 1 -> actual_takeE = 0, redirect_pc = 0x2008; the redirect clears on the first cycle redirect_ready = 1.
- BGTZ with rs = 0x8000_0000, pred_take 0 -> not taken, no redirect. Repeat with rs = 1 and pred_take 1 -> correct prediction, flush_front stays 0.
- Redirect pending with redirect_ready held 0 for 3 cycles -> stall_req = 1 and redirect_pc stable for all 3 cycles; clears after ready.
- flushE asserted while a BEQ is loading, and rst asserted while redirect_valid = 1 -> branchE = 0 on the next cycle; redirect_valid = 0 after the rst edge.
- With BRANCH_STATS_EN defined: run 4 branches with 2 mispredicts -> stat_branches = 4, stat_mispred = 2.
